arb_req_frontend: RTL and testbench
===================================

# arb_req_frontend

- Requester-side front end for the 4-port round-robin arbiter.
- Four clients each push words into a private queue. A non-empty queue drives that client's `req` bit toward the arbiter.
- On `grant`, the granted queue is popped and the word is forwarded, tagged with the client id, to the shared downstream resource.
- Also monitors the arbiter's `grant` for protocol violations.

## Interface
Parameters:
- `DATA_W`, 8, payload width per client word
- `DEPTH`, 2, entries per client queue (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `in_valid`  in  4  per-client push strobe
- `in_data`  in  4*DATA_W  client i data at bits [i*DATA_W +: DATA_W]
- `in_ready`  out  4  per-client queue not full
- `req`  out  4  to arbiter; bit i = queue i non-empty
- `grant`  in  4  from arbiter; one-hot or zero, registered by the arbiter
- `out_valid`  out  1  one-cycle pulse, forwarded word present
- `out_data`  out  DATA_W  forwarded word
- `out_id`  out  2  client index of `out_data`
- `err`  out  1  sticky protocol-error flag

## Operation
- **Push:**
  - A push on client i happens when `in_valid[i] && in_ready[i]`.
  - `in_ready[i] = (count_i != DEPTH)`. It is decoded from registered count only and never depends on `grant`.
- **Request:**
  - `req[i] = (count_i != 0)`, decoded combinationally from the count register.
  - `req` is held while the queue is non-empty, regardless of grant.
- **Pop:**
  - Client i is popped when `grant[i] && req[i]` and `grant` is exactly one-hot.
  - At most one pop per cycle.
- **Grant to an empty queue:** `grant[i]` with `req[i]==0` is legal, because the arbiter's grant lags `req` by one cycle. It is ignored: no pop, no error.
- **Invalid grant:**
  - A `grant` with more than one bit set is a protocol error.
  - No pop occurs and `err` is set.
  - `err` stays set until reset.
- **Push and pop in the same cycle on one client:**
  - Both take effect and `count_i` is unchanged.
  - This is legal only when `in_ready` was high, so a full queue does not accept a push even if it is popped that cycle.
- **Ordering:** each queue is FIFO. Pointers wrap modulo `DEPTH`.
- **Count width:** `$clog2(DEPTH)+1` bits.
- **Output:** a pop loads `out_data` (head of queue i), `out_id = i` and `out_valid = 1` on the next edge. Otherwise `out_valid = 0`.
- **Hold when idle:** `out_data` and `out_id` hold their last values when `out_valid` is 0.
- **No output backpressure:** the downstream resource always accepts.

## Timing
- **Reset values (asynchronous, while `rst` = 0):**
  - All counts and pointers 0, so `req` = 0000 and `in_ready` = 1111.
  - `out_valid` = 0, `out_data` = 0, `out_id` = 0, `err` = 0.
- **Push to request:**
  - A word pushed at edge N makes `req[i]` high after edge N.
  - The arbiter grants at edge N+1 at the earliest.
  - The pop occurs at edge N+2, which is the edge where `grant` is sampled.
- **Grant to output:** `out_valid` is high for the cycle following the edge that sampled `grant`.
- **Throughput:**
  - One word per cycle total when `grant` is held on a port with a backlog.
  - Per-client throughput is set by the arbiter.
- **Reset mid-operation:** all queued words are discarded and `out_valid` drops immediately; no partial output.

## Structure
- **Shared package:**
  - `NUM_CLIENTS = 4`, `ID_W = 2`.
  - Function `onehot0(grant)`, which returns 1 if zero or one bit is set; reused by the arbiter bench checker.
- **Sub-module `req_queue`:**
  - Single-client FIFO parameterised by `DATA_W` and `DEPTH`, with ports `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Instantiated 4× via generate.
- **Top-level logic:** the grant decode, one-hot check, output register and `err` flag live in `arb_req_frontend`.

## Test plan
1. **Reset:** hold `rst` = 0 for 2 cycles.
   - Required: `req` = 0000, `in_ready` = 1111, `out_valid` = 0 and `err` = 0.
   - Release, then pull `rst` low mid-traffic: all outputs return to these values immediately.
2. **Single client:** push 0xA1, 0xA2 into client 2, then drive `grant` = 0100 for 2 cycles.
   - Required: two `out_valid` pulses, 0xA1 then 0xA2, both with `out_id` = 2.
   - `req[2]` falls after the second pop.
3. **Stale grant:** hold `grant` = 0100 for a third cycle after the queue empties.
   - Required: no `out_valid` and `err` stays 0.
4. **Full queue:**
   - Push 3 words into client 0 with `DEPTH` = 2: only 2 are accepted, and `in_ready[0]` = 0 after the second.
   - Push and grant simultaneously while full: the push is refused, one word pops, and `in_ready[0]` returns to 1.
5. **With the real arbiter:** connect `arbiter_rr` and preload each client i with words 0xi0, 0xi1.
   - Required: `out_id` sequence follows round-robin (e.g. 0,1,2,3,0,1,2,3) and per-client data stays in order.
6. **Illegal grant:** drive `grant` = 0011 for one cycle with clients 0 and 1 non-empty.
   - Required: no pop, counts unchanged, `err` = 1 and held until reset.

Source files
------------

// File: rtl/arb_req_frontend_pkg.sv
// Shared constants and helpers for the arbiter requester front end.
// onehot0() is also used by the arbiter-side checkers.
package arb_req_frontend_pkg;

  localparam int NUM_CLIENTS = 4;
  localparam int ID_W        = 2;

  // True when no bit or exactly one bit of g is set
  function automatic logic onehot0(input logic [NUM_CLIENTS-1:0] g);
    return (g & (g - 1'b1)) == '0;
  endfunction

endpackage

// File: rtl/req_queue.sv
// Single-client FIFO. Pointers wrap naturally because DEPTH is a power of two.
// The storage array is not reset; only pointers and count are.
module req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arb_req_frontend.sv
// Requester-side front end: four client FIFOs raise req, a one-hot grant pops
// one of them into a registered, id-tagged output; multi-hot grants set err.
module arb_req_frontend
  import arb_req_frontend_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        in_valid,
  input  logic [NUM_CLIENTS*DATA_W-1:0] in_data,
  output logic [NUM_CLIENTS-1:0]        in_ready,
  output logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        grant,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [ID_W-1:0]               out_id,
  output logic                          err
);

  logic [NUM_CLIENTS-1:0] full;
  logic [NUM_CLIENTS-1:0] empty;
  logic [NUM_CLIENTS-1:0] push;
  logic [NUM_CLIENTS-1:0] pop;
  logic [DATA_W-1:0]      head [NUM_CLIENTS];

  logic                   grant_ok;
  logic                   grant_bad;
  logic                   vld_p0;
  logic [ID_W-1:0]        id_p0;
  logic [DATA_W-1:0]      data_p0;

  assign in_ready = ~full;
  assign req      = ~empty;

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
    assign push[gi] = in_valid[gi] & in_ready[gi];

    req_queue #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push[gi]),
      .pop   (pop[gi]),
      .din   (in_data[gi*DATA_W +: DATA_W]),
      .dout  (head[gi]),
      .full  (full[gi]),
      .empty (empty[gi])
    );
  end

  // Grant to an empty queue is a normal artefact of arbiter latency, not an error
  assign grant_ok  = (grant != '0) && onehot0(grant);
  assign grant_bad = !onehot0(grant);
  assign pop       = grant_ok ? (grant & req) : '0;

  always_comb begin
    vld_p0  = 1'b0;
    id_p0   = '0;
    data_p0 = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pop[i]) begin
        vld_p0  = 1'b1;
        id_p0   = ID_W'(i);
        data_p0 = head[i];
      end
    end
  end

  // p0 -> output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= vld_p0;
      if (vld_p0) begin
        out_data <= data_p0;
        out_id   <= id_p0;
      end
      err <= err | grant_bad;
    end
  end

endmodule

// File: tb/tb_arb_req_frontend.sv
// Scoreboard bench for arb_req_frontend: directed stimulus pushes expected
// {id,data} pairs, a negedge monitor pops them whenever out_valid is seen.
module tb_arb_req_frontend;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [3:0]  grant_dir;
  logic [3:0]  arb_grant;
  logic [1:0]  arb_last;
  logic        arb_en;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  assign grant = arb_en ? arb_grant : grant_dir;

  arb_req_frontend #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .err       (err)
  );

  // Reference round-robin arbiter: registered one-hot grant, search starts after last winner
  function automatic logic [4:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [4:0] res;
    logic [1:0] idx;
    res = 5'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (res[4] == 1'b0 && r[idx]) res = {1'b1, 2'b0, idx};
    end
    return res;
  endfunction

  logic [4:0] pick;
  assign pick = rr_pick(req, arb_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_grant <= 4'b0;
      arb_last  <= 2'd3;
    end else if (!arb_en) begin
      arb_grant <= 4'b0;
    end else if (pick[4]) begin
      arb_grant <= 4'b1 << pick[1:0];
      arb_last  <= pick[1:0];
    end else begin
      arb_grant <= 4'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [1:0] id, input logic [7:0] data);
    exp_q.push_back({id, data});
  endtask

  // Monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got id=%0d data=%h, expected no output", out_id, out_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({out_id, out_data} !== e) begin
          n_err++;
          $display("FAIL out_word: got id=%0d data=%h, expected id=%0d data=%h",
                   out_id, out_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 4'b0;
    in_data   = 32'h0;
    grant_dir = 4'b0;
    arb_en    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'hF);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Single client, two words, then a stale grant
    in_valid = 4'b0100;
    in_data  = 32'h00A1_0000;
    step();
    in_data  = 32'h00A2_0000;
    step();
    in_valid = 4'b0;
    chk("c2_req", 32'(req), 32'h4);
    chk("c2_full", 32'(in_ready), 32'hB);
    expect_out(2'd2, 8'hA1);
    expect_out(2'd2, 8'hA2);
    grant_dir = 4'b0100;
    step();
    step();
    chk("c2_req_fall", 32'(req), 32'h0);
    step();
    chk("stale_no_out", 32'(out_valid), 32'h0);
    chk("stale_no_err", 32'(err), 32'h0);
    grant_dir = 4'b0;
    step();

    // Full queue on client 0, then push+grant while full
    in_valid = 4'b0001;
    in_data  = 32'h0000_0010;
    step();
    in_data  = 32'h0000_0011;
    step();
    chk("c0_not_ready", 32'(in_ready), 32'hE);
    in_data  = 32'h0000_0012;
    step();
    chk("c0_still_full", 32'(in_ready), 32'hE);
    in_data   = 32'h0000_0013;
    grant_dir = 4'b0001;
    expect_out(2'd0, 8'h10);
    step();
    chk("c0_ready_back", 32'(in_ready), 32'hF);
    in_valid = 4'b0;
    expect_out(2'd0, 8'h11);
    step();
    grant_dir = 4'b0;
    step();
    chk("c0_drained", 32'(req), 32'h0);

    // Illegal multi-hot grant
    in_valid = 4'b0011;
    in_data  = 32'h0000_3130;
    step();
    in_valid  = 4'b0;
    grant_dir = 4'b0011;
    step();
    grant_dir = 4'b0;
    chk("bad_err_set", 32'(err), 32'h1);
    chk("bad_no_pop", 32'(req), 32'h3);
    chk("bad_no_out", 32'(out_valid), 32'h0);
    step();
    chk("bad_err_held", 32'(err), 32'h1);
    expect_out(2'd0, 8'h30);
    grant_dir = 4'b0001;
    step();
    expect_out(2'd1, 8'h31);
    grant_dir = 4'b0010;
    step();
    grant_dir = 4'b0;
    step();
    chk("bad_err_sticky", 32'(err), 32'h1);
    chk("bad_drained", 32'(req), 32'h0);

    // Reset mid-traffic while an output is presented
    in_valid = 4'b1100;
    in_data  = 32'h6655_0000;
    step();
    in_valid = 4'b0;
    expect_out(2'd2, 8'h55);
    grant_dir = 4'b0100;
    step();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_req", 32'(req), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'hF);
    chk("mid_rst_err", 32'(err), 32'h0);
    chk("mid_rst_out_data", 32'(out_data), 32'h0);
    chk("mid_rst_out_id", 32'(out_id), 32'h0);
    grant_dir = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    // Round-robin with reference arbiter
    in_valid = 4'b1111;
    in_data  = 32'h3020_1000;
    step();
    in_data  = 32'h3121_1101;
    step();
    in_valid = 4'b0;
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < 4; c++)
        expect_out(2'(c), 8'((c << 4) | w));
    arb_en = 1'b1;
    repeat (14) step();
    arb_en = 1'b0;
    step();
    chk("rr_drained", 32'(req), 32'h0);
    chk("rr_no_err", 32'(err), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
